// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding, latency bound and lane helper for ram_ctrl.
package ram_pkg;
  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT} state_e;
  localparam int MAX_RD_LAT = 4;
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/ram_array.sv
// ram_array: byte-enabled word storage with a one-cycle registered read, no reset.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [lanes(DATA_W)-1:0]  be_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < lanes(DATA_W); i++)
      if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: handshaked single-port RAM with byte enables, RD_LAT-cycle reads
// and optional zero-fill after reset.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 9,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [lanes(DATA_W)-1:0]  be,
  output logic                      ready,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy
);
  localparam int NB = lanes(DATA_W);
  localparam int WI = RD_LAT > 1 ? RD_LAT - 2 : 0;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, a_addr;
  logic [RD_LAT-1:0] v_q;
  logic [DATA_W-1:0] hold_q, arr_rd, cur, a_wdata;
  logic [NB-1:0] a_be;
  logic fill, acc, rd_acc, a_we;
  always_comb begin
    fill    = state_q == INIT;
    acc     = state_q == IDLE && req;
    rd_acc  = acc && !we;
    a_we    = fill || (acc && we);
    a_addr  = fill ? cnt_q : addr;
    a_be    = fill ? '1 : be;
    a_wdata = fill ? '0 : wdata;
    cnt_d   = fill ? cnt_q + 1'b1 : cnt_q;
    state_d = fill ? (&cnt_q ? IDLE : INIT)
            : state_q == RD_WAIT ? (v_q[WI] ? IDLE : RD_WAIT)
            : (rd_acc && RD_LAT > 1) ? RD_WAIT : IDLE;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= CLEAR_ON_RESET != 0 ? INIT : IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= (v_q << 1) | RD_LAT'(rd_acc);
      hold_q  <= rvalid ? cur : hold_q;
    end
  end
  // array output is already one cycle late; add the remaining RD_LAT-1 stages
  if (RD_LAT == 1) begin : g_nodly
    assign cur = arr_rd;
  end else begin : g_dly
    logic [RD_LAT-2:0][DATA_W-1:0] dly_q;
    logic [RD_LAT-1:0][DATA_W-1:0] sh;
    assign sh  = {dly_q, arr_rd};
    assign cur = sh[RD_LAT-1];
    always_ff @(posedge clock or posedge clear) begin
      if (clear) dly_q <= '0;
      else dly_q <= sh[RD_LAT-2:0];
    end
  end
  assign rvalid = v_q[RD_LAT-1];
  assign rdata  = rvalid ? cur : hold_q;
  assign ready  = state_q == IDLE && !clear;
  assign busy   = state_q == INIT;
  ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_arr (
    .clk_i  (clock),
    .we_i   (a_we),
    .re_i   (rd_acc),
    .addr_i (a_addr),
    .be_i   (a_be),
    .wdata_i(a_wdata),
    .rdata_o(arr_rd)
  );
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised single-port synchronous word memory for the CPU datapath; replaces the fixed 256x32 RAM.
- Adds a request/ready handshake, byte-write enables, a configurable read latency and an optional zero-fill sequence after reset.
- Sits between the memory data/address registers (MDR/MAR) and the control unit. `ready` and `rvalid` let control wait on memory instead of assuming a fixed latency.

Parameters:
- DATA_W, 32: word width in bits; multiple of 8.
- ADDR_W, 9: address width; depth = 2**ADDR_W words.
- RD_LAT, 1: read latency in cycles, legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after reset; 0 = contents left untouched.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte write enables; bit i gates wdata[8i+7:8i].
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; rdata holds a new read result.
- rdata  out  DATA_W  read data; holds its value until the next read completes.
- busy  out  1  zero-fill in progress.

Behaviour:
- Reset values (async on clear): ready=0, rvalid=0, rdata=0; busy=CLEAR_ON_RESET; fill counter=0; pending read dropped.
- Array contents are never touched by clear itself.
- State machine: INIT, IDLE, RD_WAIT.
  - After clear deasserts: INIT if CLEAR_ON_RESET=1, else IDLE.
- INIT:
  - Writes 0 to address = counter, one word per cycle, ascending from 0.
  - Takes exactly 2**ADDR_W cycles, then goes to IDLE.
  - busy=1 and ready=0 throughout; req is ignored.
- IDLE: ready=1.
  - Write (req=1, we=1): commits at the accepting edge. Byte i is updated only where be[i]=1. be=0 is a legal no-op write.
  - Back-to-back writes run at one per cycle.
  - Read (req=1, we=0) accepted at edge T:
    - addr is captured at T.
    - rvalid=1 during cycle T+RD_LAT, with rdata = word at the captured addr.
  - If RD_LAT=1, stay in IDLE; back-to-back reads run at one per cycle.
  - If RD_LAT>1, go to RD_WAIT.
- RD_WAIT:
  - ready=0 for cycles T+1 .. T+RD_LAT-1; req is ignored.
  - Returns to IDLE so that ready=1 in cycle T+RD_LAT, the same cycle as rvalid.
  - A new request may be accepted in that cycle.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new data. No stale forwarding window.
- Ignored requests have no side effects. The requester holds req/we/addr/wdata/be until it sees ready=1.
- All addresses are valid; there is no range error, and addresses wrap naturally at ADDR_W bits.
- clear asserted mid-read: rvalid is never produced for that read, and rdata returns to 0.
- clear asserted mid-INIT: the fill restarts from address 0.
- rvalid is never high on two consecutive cycles unless RD_LAT=1 and reads are issued back-to-back.

Decomposition:
- Shared package ram_pkg holds:
  - state encoding constants (INIT, IDLE, RD_WAIT);
  - the max RD_LAT constant (4);
  - the byte-lane count function DATA_W/8.
- Sub-module ram_array:
  - holds the storage only: byte-enabled synchronous write and a registered read of one cycle;
  - has no reset on the array.
- ram_ctrl holds:
  - the FSM;
  - the fill counter;
  - the (RD_LAT-1)-stage valid/data delay pipeline;
  - the write-port mux between fill writes and user writes.

Test Plan:
- Reset, ADDR_W=4, CLEAR_ON_RESET=1 -> busy=1 and ready=0 for exactly 16 cycles, then ready=1. A read of addr 0x5 then gives rdata=0x00000000 with rvalid.
- Write 0xA5A5A5A5 to 0x00 with be=4'hF, then read 0x00, RD_LAT=1 -> rvalid one cycle after acceptance, rdata=0xA5A5A5A5.
- Write 0x5A5A5A5A to 0x01, then write 0x000000FF with be=4'b0001, then write 0xFFFFFFFF with be=0 -> read 0x01 returns 0x5A5A5AFF.
- RD_LAT=3: read of 0x00 accepted at edge T, with req held high and addr changed to 0x01 during the wait -> ready=0 for 2 cycles and the held req is ignored. rvalid at T+3 with rdata=0xA5A5A5A5; the 0x01 read is then accepted in that same cycle.
- Write 0x12345678 to 0x07, then read 0x07 on the next cycle -> rdata=0x12345678.
- Assert clear one cycle after a read is accepted with RD_LAT=3 -> rvalid stays 0, rdata=0, and busy re-asserts since CLEAR_ON_RESET=1.
